// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, waits for lock, retries on
// timeout, qualifies lock stability and only then releases the core reset.
// Also services relock requests and acknowledges them once RUN is reached.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 74250,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       relock_ack,
  output logic [7:0] retry_count,
  output logic [1:0] state
);

  localparam logic [1:0] ST_PLLRST = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STABLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_lockedS;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic [7:0]       r_retry;
  logic             r_pllRst;
  logic             r_coreReset;
  logic             r_ready;
  logic             r_ack;

  logic [1:0]       w_nextState;
  logic             w_retryInc;
  logic             w_pendingNow;
  logic             w_enterRun;

  // Next-state decision; all lock-based choices use the synchronised lock.
  always_comb begin
    w_nextState = r_state;
    w_retryInc  = 1'b0;
    case (r_state)
      ST_PLLRST: begin
        if (r_cnt == RST_LAST) w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_lockedS) begin
          w_nextState = ST_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_nextState = ST_PLLRST;
          w_retryInc  = 1'b1;
        end
      end
      ST_STABLE: begin
        // A lock drop here is treated as a glitch, not a retry
        if (!r_lockedS) begin
          w_nextState = ST_WAIT;
        end else if (r_cnt == STABLE_LAST) begin
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        // Lock loss wins over a simultaneous relock request
        if (!r_lockedS) begin
          w_nextState = ST_PLLRST;
          w_retryInc  = 1'b1;
        end else if (relock_req) begin
          w_nextState = ST_PLLRST;
        end
      end
      default: w_nextState = ST_PLLRST;
    endcase
  end

  // Pending relock bookkeeping and detection of the first RUN cycle.
  always_comb begin
    w_pendingNow = r_pending | relock_req;
    w_enterRun   = (w_nextState == ST_RUN) && (r_state != ST_RUN);
  end

  // Two-flop synchroniser for the asynchronous PLL lock pin.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_lockedS <= 1'b0;
    end else begin
      r_sync1   <= pll_locked;
      r_lockedS <= r_sync1;
    end
  end

  // State and shared cycle counter; the counter restarts on every transition
  // and sits idle at zero in RUN.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= ST_PLLRST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      if ((w_nextState != r_state) || (r_state == ST_RUN)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Saturating retry counter, cleared only by rst.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_retry <= 8'd0;
    end else if (w_retryInc && (r_retry != 8'hFF)) begin
      r_retry <= r_retry + 8'd1;
    end
  end

  // Relock request tracking: the ack fires on RUN entry when a request is
  // outstanding, and a request arriving on the ack cycle stays pending.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
    end else begin
      r_ack <= w_enterRun && w_pendingNow;
      if (r_ack) begin
        r_pending <= relock_req;
      end else begin
        r_pending <= w_pendingNow;
      end
    end
  end

  // Registered output decode, aligned with the registered state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_pllRst    <= 1'b1;
      r_coreReset <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_pllRst    <= (w_nextState == ST_PLLRST);
      r_coreReset <= (w_nextState != ST_RUN);
      r_ready     <= (w_nextState == ST_RUN);
    end
  end

  assign pll_rst     = r_pllRst;
  assign core_reset  = r_coreReset;
  assign ready       = r_ready;
  assign relock_ack  = r_ack;
  assign retry_count = r_retry;
  assign state       = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed testbench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

  localparam logic [1:0] ST_PLLRST = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_STABLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  logic       refclk;
  logic       rst;
  logic       pllLocked;
  logic       relockReq;
  logic       pllRst;
  logic       coreReset;
  logic       ready;
  logic       relockAck;
  logic [7:0] retryCount;
  logic [1:0] state;

  int checkCount;
  int passCount;
  int runLen;

  pll_lock_sequencer #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (20)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pllLocked),
    .relock_req (relockReq),
    .pll_rst    (pllRst),
    .core_reset (coreReset),
    .ready      (ready),
    .relock_ack (relockAck),
    .retry_count(retryCount),
    .state      (state)
  );

  // Reference clock, 10 time units per period
  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitState(input logic [1:0] target, input int budget, input string tag);
    int n = 0;
    while ((state != target) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(state), 32'(target));
  endtask

  task automatic measureRun(input logic [1:0] st, output int n);
    n = 0;
    while ((state == st) && (n < 100)) begin
      n++;
      tick();
    end
  endtask

  task automatic applyStimulus(input logic resetVal, input logic lockedVal, input logic relockVal);
    rst       = resetVal;
    pllLocked = lockedVal;
    relockReq = relockVal;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " state"},      32'(state),      32'(ST_PLLRST));
    checkOutput({tag, " pll_rst"},    32'(pllRst),     32'd1);
    checkOutput({tag, " core_reset"}, 32'(coreReset),  32'd1);
    checkOutput({tag, " ready"},      32'(ready),      32'd0);
    checkOutput({tag, " relock_ack"}, 32'(relockAck),  32'd0);
    checkOutput({tag, " retry"},      32'(retryCount), 32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;

    // Scenario 1: clean bring-up with lock held high
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    checkResetValues("reset");
    rst = 1'b0;
    checkOutput("s1 pll_rst at start", 32'(pllRst), 32'd1);
    measureRun(ST_PLLRST, runLen);
    checkOutput("s1 pll_rst length", 32'(runLen), 32'd4);
    checkOutput("s1 pll_rst falls", 32'(pllRst), 32'd0);
    waitState(ST_STABLE, 10, "s1 reach STABLE");
    checkOutput("s1 core_reset in STABLE", 32'(coreReset), 32'd1);
    measureRun(ST_STABLE, runLen);
    checkOutput("s1 STABLE length", 32'(runLen), 32'd8);
    checkOutput("s1 state RUN", 32'(state), 32'(ST_RUN));
    checkOutput("s1 core_reset low", 32'(coreReset), 32'd0);
    checkOutput("s1 ready high", 32'(ready), 32'd1);
    checkOutput("s1 no ack", 32'(relockAck), 32'd0);
    checkOutput("s1 retry", 32'(retryCount), 32'd0);

    // Scenario 2: no lock, three timeouts
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      measureRun(ST_PLLRST, runLen);
      checkOutput($sformatf("s2 PLLRST length %0d", i), 32'(runLen), 32'd4);
      measureRun(ST_WAIT, runLen);
      checkOutput($sformatf("s2 WAIT length %0d", i), 32'(runLen), 32'd20);
      checkOutput($sformatf("s2 retry after timeout %0d", i), 32'(retryCount), 32'(i));
    end

    // Scenario 3: one-cycle lock glitch in the middle of STABLE
    pllLocked = 1'b1;
    waitState(ST_STABLE, 40, "s3 reach STABLE");
    repeat (3) tick();
    pllLocked = 1'b0;
    tick();
    pllLocked = 1'b1;
    waitState(ST_WAIT, 6, "s3 glitch to WAIT");
    checkOutput("s3 retry unchanged", 32'(retryCount), 32'd3);
    waitState(ST_STABLE, 6, "s3 back to STABLE");
    checkOutput("s3 core_reset held", 32'(coreReset), 32'd1);
    measureRun(ST_STABLE, runLen);
    checkOutput("s3 full STABLE length", 32'(runLen), 32'd8);
    checkOutput("s3 state RUN", 32'(state), 32'(ST_RUN));

    // Scenario 4: lock loss in RUN, then relock request while in WAIT
    pllLocked = 1'b0;
    repeat (3) tick();
    checkOutput("s4 state PLLRST", 32'(state), 32'(ST_PLLRST));
    checkOutput("s4 core_reset", 32'(coreReset), 32'd1);
    checkOutput("s4 ready", 32'(ready), 32'd0);
    checkOutput("s4 retry", 32'(retryCount), 32'd4);
    waitState(ST_WAIT, 10, "s4 reach WAIT");
    relockReq = 1'b1;
    tick();
    relockReq = 1'b0;
    checkOutput("s4 no restart in WAIT", 32'(state), 32'(ST_WAIT));
    pllLocked = 1'b1;
    waitState(ST_RUN, 40, "s4 reach RUN");
    checkOutput("s4 ack on RUN entry", 32'(relockAck), 32'd1);

    // Scenario 5: relock request on the ack cycle, then a plain RUN request
    relockReq = 1'b1;
    tick();
    relockReq = 1'b0;
    checkOutput("s5 ack-cycle restart", 32'(state), 32'(ST_PLLRST));
    checkOutput("s5 ack single cycle", 32'(relockAck), 32'd0);
    checkOutput("s5 retry unchanged", 32'(retryCount), 32'd4);
    waitState(ST_RUN, 40, "s5 reach RUN again");
    checkOutput("s5 ack again", 32'(relockAck), 32'd1);
    tick();
    checkOutput("s5 ack cleared", 32'(relockAck), 32'd0);
    relockReq = 1'b1;
    tick();
    relockReq = 1'b0;
    checkOutput("s5 RUN request restart", 32'(state), 32'(ST_PLLRST));
    checkOutput("s5 RUN request retry", 32'(retryCount), 32'd4);
    waitState(ST_RUN, 40, "s5 reach RUN third");
    checkOutput("s5 ack third", 32'(relockAck), 32'd1);
    tick();
    checkOutput("s5 ack third cleared", 32'(relockAck), 32'd0);

    // Scenario 6: saturate the retry counter, then reset mid-WAIT
    pllLocked = 1'b0;
    repeat (300 * 24 + 10) tick();
    checkOutput("s6 retry saturated", 32'(retryCount), 32'd255);
    waitState(ST_WAIT, 30, "s6 reach WAIT");
    repeat (2) tick();
    relockReq = 1'b1;
    tick();
    relockReq = 1'b0;
    rst = 1'b1;
    tick();
    checkResetValues("s6 mid-WAIT reset");
    rst       = 1'b0;
    pllLocked = 1'b1;
    waitState(ST_RUN, 40, "s6 reach RUN");
    checkOutput("s6 pending discarded", 32'(relockAck), 32'd0);
    checkOutput("s6 retry after reset", 32'(retryCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
